// File: rtl/midi_msg_parser.sv
//------------------------------------------------------------------------------
// Module   : midi_msg_parser
// Purpose  : Assembles MIDI channel-voice messages from a UART byte stream,
//            with running status, real-time passthrough and SysEx discard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module midi_msg_parser #(
   parameter bit         OMNI        = 1'b1,
   parameter logic [3:0] CHANNEL     = 4'd0,
   parameter bit         VEL0_IS_OFF = 1'b1
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Msg_Valid,
   output logic [7:0] o_Msg_Status,
   output logic [6:0] o_Msg_Data1,
   output logic [6:0] o_Msg_Data2,
   output logic       o_Rt_Valid,
   output logic [7:0] o_Rt_Byte,
   output logic       o_Err
);

   typedef enum logic [1:0] {
      S_NO_STATUS = 2'd0,
      S_WAIT_D1   = 2'd1,
      S_WAIT_D2   = 2'd2,
      S_SYSEX     = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] rs_q, rs_d;
   logic [6:0] d1_q, d1_d;

   logic       msg_valid_q, msg_valid_d;
   logic [7:0] msg_status_q, msg_status_d;
   logic [6:0] msg_d1_q, msg_d1_d;
   logic [6:0] msg_d2_q, msg_d2_d;
   logic       rt_valid_q, rt_valid_d;
   logic [7:0] rt_byte_q, rt_byte_d;
   logic       err_q, err_d;

   logic       w_is_data;
   logic       w_is_rt;
   logic       w_is_chan;
   logic       w_is_f0;
   logic       w_one_byte;
   logic       w_chan_ok;
   logic       w_emit;
   logic [6:0] w_emit_d1;
   logic [6:0] w_emit_d2;

   assign w_is_data  = ~i_Rx_Byte[7];
   assign w_is_rt    = (i_Rx_Byte[7:3] == 5'b11111);
   assign w_is_chan  = i_Rx_Byte[7] && (i_Rx_Byte[7:4] != 4'hF);
   assign w_is_f0    = (i_Rx_Byte == 8'hF0);
   assign w_one_byte = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
   assign w_chan_ok  = OMNI || (rs_q[3:0] == CHANNEL);

   always_comb begin
      state_d      = state_q;
      rs_d         = rs_q;
      d1_d         = d1_q;
      msg_valid_d  = 1'b0;
      msg_status_d = msg_status_q;
      msg_d1_d     = msg_d1_q;
      msg_d2_d     = msg_d2_q;
      rt_valid_d   = 1'b0;
      rt_byte_d    = rt_byte_q;
      err_d        = 1'b0;
      w_emit       = 1'b0;
      w_emit_d1    = 7'd0;
      w_emit_d2    = 7'd0;

      if (i_Rx_DV) begin
         if (w_is_rt) begin
            rt_valid_d = 1'b1;
            rt_byte_d  = i_Rx_Byte;
         end else if (w_is_data) begin
            case (state_q)
               S_WAIT_D1: begin
                  d1_d = i_Rx_Byte[6:0];
                  if (w_one_byte) begin
                     w_emit    = 1'b1;
                     w_emit_d1 = i_Rx_Byte[6:0];
                  end else begin
                     state_d = S_WAIT_D2;
                  end
               end
               S_WAIT_D2: begin
                  w_emit    = 1'b1;
                  w_emit_d1 = d1_q;
                  w_emit_d2 = i_Rx_Byte[6:0];
                  state_d   = S_WAIT_D1;
               end
               default: ;
            endcase
         end else begin
            // Only a half-received two-byte message counts as aborted.
            err_d = (state_q == S_WAIT_D2);
            if (w_is_chan) begin
               rs_d    = i_Rx_Byte;
               state_d = S_WAIT_D1;
            end else if (w_is_f0) begin
               rs_d    = 8'h00;
               state_d = S_SYSEX;
            end else begin
               rs_d    = 8'h00;
               state_d = S_NO_STATUS;
            end
         end
      end

      // Filtered messages still advance the parser but leave the fields alone.
      if (w_emit && w_chan_ok) begin
         msg_valid_d  = 1'b1;
         msg_d1_d     = w_emit_d1;
         msg_d2_d     = w_emit_d2;
         if (VEL0_IS_OFF && (rs_q[7:4] == 4'h9) && (w_emit_d2 == 7'd0)) begin
            msg_status_d = {4'h8, rs_q[3:0]};
         end else begin
            msg_status_d = rs_q;
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         state_q      <= S_NO_STATUS;
         rs_q         <= 8'h00;
         d1_q         <= 7'd0;
         msg_valid_q  <= 1'b0;
         msg_status_q <= 8'h00;
         msg_d1_q     <= 7'd0;
         msg_d2_q     <= 7'd0;
         rt_valid_q   <= 1'b0;
         rt_byte_q    <= 8'h00;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rs_q         <= rs_d;
         d1_q         <= d1_d;
         msg_valid_q  <= msg_valid_d;
         msg_status_q <= msg_status_d;
         msg_d1_q     <= msg_d1_d;
         msg_d2_q     <= msg_d2_d;
         rt_valid_q   <= rt_valid_d;
         rt_byte_q    <= rt_byte_d;
         err_q        <= err_d;
      end
   end

   assign o_Msg_Valid  = msg_valid_q;
   assign o_Msg_Status = msg_status_q;
   assign o_Msg_Data1  = msg_d1_q;
   assign o_Msg_Data2  = msg_d2_q;
   assign o_Rt_Valid   = rt_valid_q;
   assign o_Rt_Byte    = rt_byte_q;
   assign o_Err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
//------------------------------------------------------------------------------
// Module   : tb_midi_msg_parser
// Purpose  : Self-checking bench for midi_msg_parser (three parameter sets).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_midi_msg_parser;

   // dut0: omni, vel0 rewrite; dut1: channel 2 only, vel0 rewrite; dut2: omni, no rewrite
   localparam logic [2:0]  OMNI_P = 3'b101;
   localparam logic [2:0]  VEL_P  = 3'b011;
   localparam logic [11:0] CH_P   = 12'h020;

   logic       clk;
   logic       rst_n;
   logic       rx_dv;
   logic [7:0] rx_byte;

   logic       mv  [3];
   logic [7:0] ms  [3];
   logic [6:0] md1 [3];
   logic [6:0] md2 [3];
   logic       rv  [3];
   logic [7:0] rb  [3];
   logic       er  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      midi_msg_parser #(
         .OMNI        (OMNI_P[g]),
         .CHANNEL     (CH_P[g*4 +: 4]),
         .VEL0_IS_OFF (VEL_P[g])
      ) u_dut (
         .i_Clock      (clk),
         .i_Rst_n      (rst_n),
         .i_Rx_DV      (rx_dv),
         .i_Rx_Byte    (rx_byte),
         .o_Msg_Valid  (mv[g]),
         .o_Msg_Status (ms[g]),
         .o_Msg_Data1  (md1[g]),
         .o_Msg_Data2  (md2[g]),
         .o_Rt_Valid   (rv[g]),
         .o_Rt_Byte    (rb[g]),
         .o_Err        (er[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Reference model: running status plus a queue of collected data bytes.
   int         m_rs = -1;
   bit         m_sysex = 1'b0;
   int         m_q[$];
   logic       e_v   [3];
   logic [7:0] e_st  [3];
   logic [6:0] e_d1  [3];
   logic [6:0] e_d2  [3];
   logic       e_rt;
   logic [7:0] e_rtb;
   logic       e_err;

   function automatic int need(input int s);
      return ((s / 16) == 12 || (s / 16) == 13) ? 1 : 2;
   endfunction

   task automatic model_reset();
      m_rs = -1;
      m_sysex = 1'b0;
      m_q.delete();
      for (int k = 0; k < 3; k++) begin
         e_v[k] = 0; e_st[k] = 0; e_d1[k] = 0; e_d2[k] = 0;
      end
      e_rt = 0; e_rtb = 0; e_err = 0;
   endtask

   task automatic model_step(input logic dv, input logic [7:0] b);
      int d1, d2, st;
      for (int k = 0; k < 3; k++) e_v[k] = 0;
      e_rt = 0;
      e_err = 0;
      if (!dv) return;
      if (b >= 8'hF8) begin
         e_rt = 1; e_rtb = b;
      end else if (b < 8'h80) begin
         if (!m_sysex && m_rs >= 0) begin
            m_q.push_back(int'(b));
            if (m_q.size() == need(m_rs)) begin
               d1 = m_q[0];
               d2 = (need(m_rs) == 2) ? m_q[1] : 0;
               m_q.delete();
               for (int k = 0; k < 3; k++) begin
                  if (OMNI_P[k] || (m_rs % 16) == int'(CH_P[k*4 +: 4])) begin
                     st = m_rs;
                     if (VEL_P[k] && (m_rs / 16) == 9 && d2 == 0) st = m_rs - 16;
                     e_v[k] = 1; e_st[k] = st[7:0]; e_d1[k] = d1[6:0]; e_d2[k] = d2[6:0];
                  end
               end
            end
         end
      end else begin
         if (m_rs >= 0 && m_q.size() > 0) e_err = 1;
         m_q.delete();
         if (b <= 8'hEF) begin
            m_rs = int'(b); m_sysex = 0;
         end else if (b == 8'hF0) begin
            m_rs = -1; m_sysex = 1;
         end else begin
            m_rs = -1; m_sysex = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s dut%0d", tag, k),
             {31'd0, mv[k], ms[k], md1[k], md2[k], rv[k], rb[k], er[k]},
             {31'd0, e_v[k], e_st[k], e_d1[k], e_d2[k], e_rt, e_rtb, e_err});
      end
   endtask

   task automatic step(input logic dv, input logic [7:0] b, input string tag);
      rx_dv = dv;
      rx_byte = b;
      model_step(dv, b);
      @(posedge clk);
      #1;
      rx_dv = 1'b0;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx_dv = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all("reset");
   endtask

   typedef struct {
      logic       dv;
      logic [7:0] b;
      logic       v;
      logic [7:0] st;
      logic [6:0] d1;
      logic [6:0] d2;
      logic       rt;
      logic       err;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic dv, input logic [7:0] b, input logic v, input logic [7:0] st,
                      input logic [6:0] d1, input logic [6:0] d2, input logic rt, input logic err);
      tv.push_back('{dv, b, v, st, d1, d2, rt, err});
   endtask

   task automatic addn(input logic [7:0] b);
      add(1, b, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic addm(input logic [7:0] b, input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
      add(1, b, 1, st, d1, d2, 0, 0);
   endtask

   initial begin
      int cnt0, cnt1, r;
      logic [7:0] b;
      logic dv;
      logic [7:0] seq[6];

      rst_n = 1'b1;
      rx_dv = 1'b0;
      rx_byte = 8'h00;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      addn(8'h90); addn(8'h3C); addm(8'h64, 8'h90, 7'h3C, 7'h64);
      addn(8'h3E); addm(8'h50, 8'h90, 7'h3E, 7'h50);
      addn(8'h40); addm(8'h00, 8'h80, 7'h40, 7'h00);
      addn(8'hC5); addm(8'h07, 8'hC5, 7'h07, 7'h00); addm(8'h08, 8'hC5, 7'h08, 7'h00);
      addn(8'h90); addn(8'h3C); add(1, 8'hF8, 0, 0, 0, 0, 1, 0); addm(8'h64, 8'h90, 7'h3C, 7'h64);
      addn(8'hB0); addn(8'h07); add(1, 8'h91, 0, 0, 0, 0, 0, 1);
      addn(8'h40); addm(8'h7F, 8'h91, 7'h40, 7'h7F);
      addn(8'hF0); addn(8'h01); add(1, 8'hFA, 0, 0, 0, 0, 1, 0);
      addn(8'h02); addn(8'hF7); addn(8'h3C); addn(8'h64);
      addn(8'h90); addn(8'h3C); add(0, 8'h7F, 0, 0, 0, 0, 0, 0); addm(8'h64, 8'h90, 7'h3C, 7'h64);
      addn(8'h90); addn(8'h3C); add(1, 8'hF6, 0, 0, 0, 0, 0, 1); addn(8'h3C); addn(8'h64);
      addn(8'hF0); addn(8'h01); addn(8'h95); addn(8'h20); addm(8'h30, 8'h95, 7'h20, 7'h30);
      addn(8'hE0); addn(8'h00); addm(8'h40, 8'hE0, 7'h00, 7'h40);
      addn(8'hD3); addm(8'h7F, 8'hD3, 7'h7F, 7'h00);

      foreach (tv[i]) begin
         step(tv[i].dv, tv[i].b, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d strobes", i), {61'd0, mv[0], rv[0], er[0]},
             {61'd0, tv[i].v, tv[i].rt, tv[i].err});
         if (tv[i].v)
            chk($sformatf("vec%0d fields", i), {42'd0, ms[0], md1[0], md2[0]},
                {42'd0, tv[i].st, tv[i].d1, tv[i].d2});
         if (tv[i].rt)
            chk($sformatf("vec%0d rtbyte", i), {56'd0, rb[0]}, {56'd0, tv[i].b});
      end

      // Channel filter: only the channel-2 message reaches dut1.
      do_reset();
      seq = '{8'h93, 8'h40, 8'h40, 8'h92, 8'h40, 8'h40};
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, seq[i], "omni0");
         if (mv[0]) cnt0++;
         if (mv[1]) cnt1++;
      end
      chk("omni0 dut1 count", 64'(cnt1), 64'd1);
      chk("omni0 dut1 fields", {42'd0, ms[1], md1[1], md2[1]}, {42'd0, 8'h92, 7'h40, 7'h40});
      chk("omni0 dut0 count", 64'(cnt0), 64'd2);

      // Reset in the middle of a message discards it.
      do_reset();
      step(1'b1, 8'h90, "rstmid");
      step(1'b1, 8'h3C, "rstmid");
      do_reset();
      step(1'b1, 8'h64, "rstmid");
      chk("rstmid no strobe", {63'd0, mv[0]}, 64'd0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            r = $urandom_range(0, 99);
            dv = 1'b1;
            if (r < 10) begin
               dv = 1'b0;
               b = 8'($urandom);
            end else if (r < 55) begin
               b = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
            end else if (r < 77) begin
               b = {1'b1, 3'($urandom_range(0, 6)), 4'(($urandom_range(0, 2) == 0) ? 2 : $urandom_range(0, 15))};
            end else if (r < 87) begin
               b = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'($urandom_range(8'hF1, 8'hF7));
            end else begin
               b = 8'($urandom_range(8'hF8, 8'hFF));
            end
            step(dv, b, "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
